mux_ctrl_n_1: RTL and testbench



---
 rtl/mux_ctrl_n_1_if.sv | 34 +++
 rtl/mux_ctrl_n_1.sv | 93 +++++++++
 tb/tb_mux_ctrl_n_1.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux_ctrl_n_1_if.sv
// rtl/mux_ctrl_n_1_if.sv - strobe/mask/select bundle for mux_ctrl_n_1; frame_cnt_o exists only with MUX_CTRL_FRAME_CNT_EN
interface mux_ctrl_n_1_if #(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int FRAME_W = 16
);
  logic              clr_i;
  logic              reg_out_i;
  logic [NUM_CH-1:0] ch_mask_i;
  logic [SEL_W-1:0]  ctrl_mux_o;
  logic              regout_matrix_o;
  logic              mask_err_o;
`ifdef MUX_CTRL_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_o;

  modport master (
    output clr_i, reg_out_i, ch_mask_i,
    input  ctrl_mux_o, regout_matrix_o, mask_err_o, frame_cnt_o
  );
  modport slave (
    input  clr_i, reg_out_i, ch_mask_i,
    output ctrl_mux_o, regout_matrix_o, mask_err_o, frame_cnt_o
  );
`else
  modport master (
    output clr_i, reg_out_i, ch_mask_i,
    input  ctrl_mux_o, regout_matrix_o, mask_err_o
  );
  modport slave (
    input  clr_i, reg_out_i, ch_mask_i,
    output ctrl_mux_o, regout_matrix_o, mask_err_o
  );
`endif
endinterface

// File: rtl/mux_ctrl_n_1.sv
// rtl/mux_ctrl_n_1.sv - N:1 readout mux select sequencer with channel masking; frame counter with MUX_CTRL_FRAME_CNT_EN
module mux_ctrl_n_1 #(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int FRAME_W = 16
) (
  input logic           SYS_CLK,
  input logic           SYS_RST,
  mux_ctrl_n_1_if.slave bus
);
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_mask;
  logic              r_err;

  logic [SEL_W-1:0]  hi_idx;
  logic [SEL_W-1:0]  nxt_idx;
  logic [SEL_W-1:0]  first_new;
  logic              mask_nz;
  logic              last;
  logic              frame_end;

  // Highest enabled channel of the active mask marks the end of a frame
  always_comb begin
    hi_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_mask[k]) hi_idx = SEL_W'(k);
    end
  end

  // Next enabled channel strictly above the current select
  always_comb begin
    nxt_idx = r_sel;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (r_mask[k] && (SEL_W'(k) > r_sel)) nxt_idx = SEL_W'(k);
    end
  end

  // Lowest enabled channel of the incoming mask, 0 when the mask is empty
  always_comb begin
    first_new = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.ch_mask_i[k]) first_new = SEL_W'(k);
    end
  end

  assign mask_nz   = |r_mask;
  assign last      = (r_sel == hi_idx);
  // A strobe colliding with a soft restart is dropped, so it never ends a frame
  assign frame_end = bus.reg_out_i & last & mask_nz & ~bus.clr_i;

  // Select/mask/error state: reset, soft restart, then strobe handling
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_sel  <= '0;
      r_mask <= '1;
      r_err  <= 1'b0;
    end else if (bus.clr_i) begin
      r_mask <= bus.ch_mask_i;
      r_sel  <= first_new;
      r_err  <= 1'b0;
    end else if (bus.reg_out_i) begin
      if (!mask_nz) begin
        // Nothing to visit: flag it, keep the select, and pick up a fresh mask
        r_err  <= 1'b1;
        r_mask <= bus.ch_mask_i;
      end else if (last) begin
        r_mask <= bus.ch_mask_i;
        r_sel  <= first_new;
      end else begin
        r_sel <= nxt_idx;
      end
    end
  end

`ifdef MUX_CTRL_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame;

  // Completed-frame counter; a soft restart does not clear it
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_frame <= '0;
    end else if (frame_end) begin
      r_frame <= r_frame + 1'b1;
    end
  end

  assign bus.frame_cnt_o = r_frame;
`endif

  assign bus.ctrl_mux_o      = r_sel;
  assign bus.regout_matrix_o = frame_end;
  assign bus.mask_err_o      = r_err;
endmodule

// File: tb/tb_mux_ctrl_n_1.sv
// tb/tb_mux_ctrl_n_1.sv - scoreboard bench for mux_ctrl_n_1 with randomized stimulus and parameter sweep
module tb_mux_ctrl_n_1;
  logic clk;
  logic rst;

  int n_vec  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_ctrl_n_1_if #(.NUM_CH(8))  bus8 ();
  mux_ctrl_n_1_if #(.NUM_CH(2))  bus2 ();
  mux_ctrl_n_1_if #(.NUM_CH(5))  bus5 ();
  mux_ctrl_n_1_if #(.NUM_CH(64)) bus64 ();

  mux_ctrl_n_1 #(.NUM_CH(8))  dut   (.SYS_CLK(clk), .SYS_RST(rst), .bus(bus8));
  mux_ctrl_n_1 #(.NUM_CH(2))  dut2  (.SYS_CLK(clk), .SYS_RST(rst), .bus(bus2));
  mux_ctrl_n_1 #(.NUM_CH(5))  dut5  (.SYS_CLK(clk), .SYS_RST(rst), .bus(bus5));
  mux_ctrl_n_1 #(.NUM_CH(64)) dut64 (.SYS_CLK(clk), .SYS_RST(rst), .bus(bus64));

  typedef struct {
    logic rg;
    int   sel;
    logic err;
    int   frame;
  } exp_t;

  exp_t exp_q[$];

  // reference model state (8 channels)
  int         m_sel;
  logic [7:0] m_mask;
  logic       m_err;
  int         m_frame;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lowest_set(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Apply one cycle of stimulus to the 8-channel DUT and queue the model's answer
  task automatic step(input logic r, input logic c, input logic s, input logic [7:0] chm);
    int   en[$];
    exp_t e;
    @(posedge clk);
    #2;
    rst            = r;
    bus8.clr_i     = c;
    bus8.reg_out_i = s;
    bus8.ch_mask_i = chm;

    for (int i = 0; i < 8; i++) if (m_mask[i]) en.push_back(i);
    e.rg = s && !c && (en.size() > 0) && (m_sel == en[en.size()-1]);

    if (r) begin
      m_sel = 0; m_mask = 8'hFF; m_err = 1'b0; m_frame = 0;
    end else if (c) begin
      m_mask = chm; m_sel = lowest_set(chm); m_err = 1'b0;
    end else if (s) begin
      if (en.size() == 0) begin
        m_err = 1'b1; m_mask = chm;
      end else if (e.rg) begin
        m_frame = (m_frame + 1) % 65536;
        m_mask  = chm;
        m_sel   = lowest_set(chm);
      end else begin
        foreach (en[i]) if (en[i] > m_sel) begin m_sel = en[i]; break; end
      end
    end
    e.sel = m_sel; e.err = m_err; e.frame = m_frame;
    exp_q.push_back(e);
  endtask

  // Monitor: regout mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    logic rg;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        rg = bus8.regout_matrix_o;
        @(posedge clk);
        #1;
        chk("regout_matrix", 64'(rg), 64'(e.rg));
        chk("ctrl_mux", 64'(bus8.ctrl_mux_o), 64'(e.sel));
        chk("mask_err", 64'(bus8.mask_err_o), 64'(e.err));
`ifdef MUX_CTRL_FRAME_CNT_EN
        chk("frame_cnt", 64'(bus8.frame_cnt_o), 64'(e.frame));
`endif
      end
    end
  end

  initial begin
    int   wait_cnt;
    logic [7:0] rm;
    rst = 1'b1;
    bus8.clr_i = 1'b0; bus8.reg_out_i = 1'b0; bus8.ch_mask_i = 8'hFF;
    bus2.clr_i = 1'b0; bus2.reg_out_i = 1'b0; bus2.ch_mask_i = '0;
    bus5.clr_i = 1'b0; bus5.reg_out_i = 1'b0; bus5.ch_mask_i = '0;
    bus64.clr_i = 1'b0; bus64.reg_out_i = 1'b0; bus64.ch_mask_i = '0;
    m_sel = 0; m_mask = 8'hFF; m_err = 1'b0; m_frame = 0;

    // reset state
    step(1, 0, 0, 8'hFF);
    step(1, 0, 0, 8'hFF);
    step(0, 0, 0, 8'hFF);

    // default mask: two full frames
    repeat (16) step(0, 0, 1, 8'hFF);

    // mask skipping
    step(0, 1, 0, 8'hA4);
    repeat (6) step(0, 0, 1, 8'hA4);

    // mask change mid-frame
    step(0, 1, 0, 8'hFF);
    repeat (3) step(0, 0, 1, 8'hFF);
    repeat (5) step(0, 0, 1, 8'h81);
    step(0, 0, 1, 8'h81);

    // zero mask, then recovery with the error held
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    repeat (3) step(0, 0, 1, 8'h10);
    step(0, 0, 0, 8'h10);
    step(0, 1, 0, 8'hFF);

    // clr/strobe collision at the last channel
    repeat (7) step(0, 0, 1, 8'hFF);
    step(0, 1, 1, 8'h24);
    step(0, 0, 0, 8'h24);

    // reset mid-frame
    repeat (2) step(0, 0, 1, 8'h24);
    step(1, 0, 1, 8'h24);
    step(0, 0, 0, 8'h24);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rm = 8'h00;
        1: rm = 8'(1 << $urandom_range(0, 7));
        default: rm = 8'($urandom);
      endcase
      step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 70), rm);
    end
    step(0, 0, 0, 8'hFF);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // parameter sweep: single top channel enabled on each width
    @(posedge clk);
    #2;
    bus2.clr_i = 1'b1;  bus2.ch_mask_i  = 2'b10;
    bus5.clr_i = 1'b1;  bus5.ch_mask_i  = 5'b10000;
    bus64.clr_i = 1'b1; bus64.ch_mask_i = {1'b1, 63'b0};
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) begin
      #1;
      bus2.clr_i = 1'b0;  bus2.reg_out_i = 1'b1;
      bus5.clr_i = 1'b0;  bus5.reg_out_i = 1'b1;
      bus64.clr_i = 1'b0; bus64.reg_out_i = 1'b1;
      @(negedge clk);
      chk("sweep2_regout", 64'(bus2.regout_matrix_o), 64'd1);
      chk("sweep5_regout", 64'(bus5.regout_matrix_o), 64'd1);
      chk("sweep64_regout", 64'(bus64.regout_matrix_o), 64'd1);
      @(posedge clk);
      #1;
      chk("sweep2_sel", 64'(bus2.ctrl_mux_o), 64'd1);
      chk("sweep5_sel", 64'(bus5.ctrl_mux_o), 64'd4);
      chk("sweep64_sel", 64'(bus64.ctrl_mux_o), 64'd63);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
